uart_transmitter: RTL and testbench

//  Serialises one parallel word into an asynchronous UART frame: start bit, DATA_BITS data bits LSB first, stop bit.

---
 rtl/uart_transmitter_pkg.sv | 32 +++
 rtl/uart_transmitter.sv | 157 +++++++++++++++
 tb/tb_uart_transmitter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_transmitter_pkg.sv
// Shared UART definitions: state encodings and default frame parameters.
// Build option UART_TX_PARITY_EN adds the PARITY state (3-bit state encoding).
package uart_transmitter_pkg;

    localparam int UART_DATA_BITS_DEF = 8;
    localparam int UART_OS_TICKS_DEF  = 16;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        UART_IDLE   = 3'd0,
        UART_START  = 3'd1,
        UART_DATA   = 3'd2,
        UART_STOP   = 3'd3,
        UART_PARITY = 3'd4
    } uart_state_e;
`else
    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_e;
`endif

    // Tick counter width: enough for the longer of a data bit and the stop period.
    function automatic int tick_cnt_width(input int os_ticks, input int sb_ticks);
        int m;
        m = (os_ticks > sb_ticks) ? os_ticks : sb_ticks;
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/uart_transmitter.sv
// UART TX: start bit, DATA_BITS data bits LSB first, optional even parity, stop bit(s).
// Define UART_TX_PARITY_EN to insert the parity bit between data and stop.
module uart_transmitter
    import uart_transmitter_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS_DEF,
    parameter int SB_TICKS  = 16,
    parameter int OS_TICKS  = UART_OS_TICKS_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_tx_start,
    input  logic                 i_bd_tick,
    input  logic [DATA_BITS-1:0] i_data,
    output logic                 o_tx,
    output logic                 o_busy,
    output logic                 o_tx_done
);

    localparam int CW = tick_cnt_width(OS_TICKS, SB_TICKS);
    localparam int IW = $clog2(DATA_BITS) + 1;

    localparam logic [CW-1:0] OS_LAST  = CW'(OS_TICKS - 1);
    localparam logic [CW-1:0] SB_LAST  = CW'(SB_TICKS - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    uart_state_e            state_q, state_d;
    logic [CW-1:0]          cnt_q,   cnt_d;
    logic [IW-1:0]          idx_q,   idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   tx_q,    tx_d;
    logic                   busy_q,  busy_d;
    logic                   done_q,  done_d;
`ifdef UART_TX_PARITY_EN
    logic                   par_q,   par_d;
`endif

    // Outputs are registered from the current state, so each line value
    // lags its state by one cycle; busy lags the same way so it still
    // reads high during the done pulse.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = 1'b1;
        busy_d  = (state_q != UART_IDLE);
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            UART_IDLE: begin
                tx_d = 1'b1;
                if (i_tx_start && !busy_q) begin
                    shift_d = i_data;
                    cnt_d   = '0;
                    state_d = UART_START;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^i_data;
`endif
                end
            end
            UART_START: begin
                tx_d = 1'b0;
                if (i_bd_tick) begin
                    if (cnt_q == OS_LAST) begin
                        cnt_d   = '0;
                        idx_d   = '0;
                        state_d = UART_DATA;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            UART_DATA: begin
                tx_d = shift_q[0];
                if (i_bd_tick) begin
                    if (cnt_q == OS_LAST) begin
                        shift_d = shift_q >> 1;
                        cnt_d   = '0;
                        if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state_d = UART_PARITY;
`else
                            state_d = UART_STOP;
`endif
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            UART_PARITY: begin
                tx_d = par_q;
                if (i_bd_tick) begin
                    if (cnt_q == OS_LAST) begin
                        cnt_d   = '0;
                        state_d = UART_STOP;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
`endif
            UART_STOP: begin
                tx_d = 1'b1;
                if (i_bd_tick) begin
                    if (cnt_q == SB_LAST) begin
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        state_d = UART_IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = UART_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= UART_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign o_tx      = tx_q;
    assign o_busy    = busy_q;
    assign o_tx_done = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: a line monitor decodes frames and
// checks them against a scoreboard of words queued at send time.
module tb_uart_transmitter;

    localparam int OS = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME_CYC = NBITS * OS;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_tx_start = 1'b0;
    logic       i_bd_tick = 1'b0;
    logic [7:0] i_data = 8'h00;
    logic       o_tx, o_busy, o_tx_done;

    always #5 i_clk = ~i_clk;

    uart_transmitter #(.DATA_BITS(8), .SB_TICKS(16), .OS_TICKS(16)) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_tx_start (i_tx_start),
        .i_bd_tick  (i_bd_tick),
        .i_data     (i_data),
        .o_tx       (o_tx),
        .o_busy     (o_busy),
        .o_tx_done  (o_tx_done)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;
    int tick_div = 1;
    int tphase = 0;
    int bit_cyc = 16;
    bit mon_en = 1'b1;
    logic [7:0] exp_q[$];
    logic [7:0] mw;

    always @(posedge i_clk) cyc <= cyc + 1;
    always @(posedge i_clk) if (o_tx_done === 1'b1) done_cnt <= done_cnt + 1;

    always @(negedge i_clk) begin
        i_bd_tick = (tphase == 0);
        tphase = (tphase + 1 >= tick_div) ? 0 : tphase + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Line monitor: sample each bit near its middle after the falling start edge.
    always begin
        @(negedge i_clk);
        if (mon_en && o_tx === 1'b0) begin
            repeat (bit_cyc / 2) @(negedge i_clk);
            chk("start_bit", o_tx, 1'b0);
            for (int b = 0; b < 8; b++) begin
                repeat (bit_cyc) @(negedge i_clk);
                mw[b] = o_tx;
            end
`ifdef UART_TX_PARITY_EN
            repeat (bit_cyc) @(negedge i_clk);
            chk("parity_bit", o_tx, ^mw);
`endif
            repeat (bit_cyc) @(negedge i_clk);
            chk("stop_bit", o_tx, 1'b1);
            chk("frame_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) chk("frame_data", mw, exp_q.pop_front());
        end
    end

    task automatic send(input logic [7:0] d, input bit push, output int t0);
        int n = 0;
        while (o_busy !== 1'b0 && n < 2000) begin
            @(negedge i_clk);
            n++;
        end
        chk("send_idle", o_busy, 1'b0);
        i_tx_start = 1'b1;
        i_data = d;
        if (push) exp_q.push_back(d);
        @(negedge i_clk);
        t0 = cyc;
        i_tx_start = 1'b0;
        i_data = 8'($urandom);
    endtask

    task automatic wait_done(input int maxc, input string tag);
        int n = 0;
        while (o_tx_done !== 1'b1 && n < maxc) begin
            @(negedge i_clk);
            n++;
        end
        chk({tag, "_done_seen"}, o_tx_done, 1'b1);
    endtask

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, dc0, bad;

        // Reset and quiet idle line.
        @(negedge i_clk);
        i_reset = 1'b1;
        repeat (3) @(negedge i_clk);
        i_reset = 1'b0;
        chk("rst_tx", o_tx, 1'b1);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_done", o_tx_done, 1'b0);
        bad = 0;
        repeat (50) begin
            @(negedge i_clk);
            if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_tx_done !== 1'b0) bad++;
        end
        chk("idle_quiet", bad, 0);

        // 0xA5 with a tick every cycle: latency and busy around done.
        send(8'hA5, 1'b1, t0);
        wait_done(400, "a5");
        chk("a5_latency", cyc - t0, FRAME_CYC);
        chk("a5_busy_at_done", o_busy, 1'b1);
        @(negedge i_clk);
        chk("a5_busy_after", o_busy, 1'b0);
        chk("a5_done_width", o_tx_done, 1'b0);
        repeat (10) @(negedge i_clk);

        // 0x3C with a tick every 4th cycle.
        tick_div = 4;
        bit_cyc = 64;
        send(8'h3C, 1'b1, t0);
        wait_done(64 * 14, "3c");
        repeat (10) @(negedge i_clk);
        tick_div = 1;
        bit_cyc = 16;
        repeat (10) @(negedge i_clk);

        // Start re-asserted mid-frame is ignored.
        dc0 = done_cnt;
        send(8'h12, 1'b1, t0);
        repeat (50) @(negedge i_clk);
        i_tx_start = 1'b1;
        i_data = 8'hFF;
        @(negedge i_clk);
        i_tx_start = 1'b0;
        wait_done(400, "12");
        repeat (300) @(negedge i_clk);
        chk("t4_done_count", done_cnt - dc0, 1);
        chk("t4_queue_empty", exp_q.size(), 0);

        // Back-to-back frames: start on the cycle after done.
        send(8'h00, 1'b1, t0);
        wait_done(400, "00");
        @(negedge i_clk);
        i_tx_start = 1'b1;
        i_data = 8'h81;
        exp_q.push_back(8'h81);
        chk("t5_idle_after_done", o_busy, 1'b0);
        @(negedge i_clk);
        t1 = cyc;
        i_tx_start = 1'b0;
        wait_done(400, "81");
        chk("t5_b2b_latency", cyc - t1, FRAME_CYC);
        repeat (20) @(negedge i_clk);
        chk("t5_queue_empty", exp_q.size(), 0);

        // Parity-relevant word (three ones).
        send(8'h07, 1'b1, t0);
        wait_done(400, "07");
        chk("07_latency", cyc - t0, FRAME_CYC);
        repeat (20) @(negedge i_clk);

        // Reset during data bit 3 of 0x55 aborts the frame.
        mon_en = 1'b0;
        dc0 = done_cnt;
        send(8'h55, 1'b0, t0);
        repeat (70) @(negedge i_clk);
        chk("t6_bit3_low", o_tx, 1'b0);
        chk("t6_busy_mid", o_busy, 1'b1);
        i_reset = 1'b1;
        @(negedge i_clk);
        chk("t6_rst_tx", o_tx, 1'b1);
        chk("t6_rst_busy", o_busy, 1'b0);
        chk("t6_rst_done", o_tx_done, 1'b0);
        i_reset = 1'b0;
        bad = 0;
        repeat (200) begin
            @(negedge i_clk);
            if (o_tx !== 1'b1 || o_busy !== 1'b0) bad++;
        end
        chk("t6_line_idle", bad, 0);
        chk("t6_no_done", done_cnt - dc0, 0);
        mon_en = 1'b1;

        repeat (20) @(negedge i_clk);
        chk("final_queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
